cnn_frame_sequencer: RTL and testbench

//  Sequences image frames from the input pixel FIFO into the CNN core (top).

---
 rtl/cnn_seq_pkg.sv | 19 +
 rtl/cnn_frame_sequencer_if.sv | 44 ++++
 rtl/seq_watchdog.sv | 28 ++
 rtl/cnn_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the CNN frame sequencer.
// Pure definitions: no logic, no latency, no flow control.
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        WAIT_RESULT = 2'd2,
        DONE        = 2'd3
    } seq_state_t;

    // Digit reported when the CNN never answers for a frame.
    localparam logic [3:0] RESULT_TIMEOUT = 4'hF;

    function automatic int num_pixels(input int img_dim);
        return img_dim * img_dim;
    endfunction

endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// Bundle of the sequencer's control, FIFO-read, CNN-pixel and CNN-result signals.
// slave = sequencer side, master = the environment (FIFO, CNN core, host control).
interface cnn_frame_sequencer_if #(
    parameter int GS_BITS  = 8,
    parameter int BCD_BITS = 4,
    parameter int D_WIDTH  = 16
);
    logic                start;
    logic                abort;
    logic [15:0]         num_frames;
    logic [D_WIDTH-1:0]  fifo_dout;
    logic                fifo_empty;
    logic                fifo_rd_en;
    logic [GS_BITS-1:0]  pixel_o;
    logic                pixel_o_valid;
    logic [BCD_BITS-1:0] digit_i;
    logic                digit_i_valid;
    logic [BCD_BITS-1:0] result_o;
    logic                result_valid;
    logic [15:0]         frame_idx_o;
    logic                busy;
    logic                done;
    logic                timeout_err;
    logic                spurious_err;

    modport slave (
        input  start, abort, num_frames,
        input  fifo_dout, fifo_empty,
        input  digit_i, digit_i_valid,
        output fifo_rd_en, pixel_o, pixel_o_valid,
        output result_o, result_valid, frame_idx_o,
        output busy, done, timeout_err, spurious_err
    );

    modport master (
        output start, abort, num_frames,
        output fifo_dout, fifo_empty,
        output digit_i, digit_i_valid,
        input  fifo_rd_en, pixel_o, pixel_o_valid,
        input  result_o, result_valid, frame_idx_o,
        input  busy, done, timeout_err, spurious_err
    );

endinterface

// File: rtl/seq_watchdog.sv
// Clearable cycle counter; o_expire is combinational, high in the enabled cycle where
// the count reaches TIMEOUT_CYCLES-1. No flow control: counts every enabled cycle.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Streams IMG_DIM*IMG_DIM pixels per frame from a FWFT FIFO to the CNN, then waits for its digit.
// Pixel path is combinational (pop = strobe, same cycle); result registered, 1 cycle after the digit.
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int GS_BITS        = 8,
    parameter int BCD_BITS       = 4,
    parameter int D_WIDTH        = 16,
    parameter int IMG_DIM        = 30,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn_frame_sequencer_if.slave  io_bus
);

    localparam int               NUM_PIXELS = num_pixels(IMG_DIM);
    localparam int               PIX_W      = $clog2(NUM_PIXELS);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NUM_PIXELS - 1);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic [15:0]         r_num_frames;
    logic [15:0]         r_frame_idx;
    logic [BCD_BITS-1:0] r_result;
    logic                r_result_valid;
    logic                r_timeout_err;
    logic                r_spurious_err;

    logic        w_abort;
    logic        w_start_ok;
    logic        w_rd_en;
    logic        w_busy;
    logic        w_done;
    logic        w_last_pop;
    logic        w_in_wait;
    logic        w_digit_acc;
    logic        w_expire;
    logic        w_timeout;
    logic        w_frame_end;
    logic [15:0] w_frame_idx_inc;
    logic        w_last_frame;
    logic        w_unused_dout;

    assign w_abort         = io_bus.abort && (r_state != IDLE);
    assign w_start_ok      = io_bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_pop      = w_rd_en && (r_pix_cnt == LAST_PIX);
    assign w_in_wait       = (r_state == WAIT_RESULT);
    assign w_digit_acc     = w_in_wait && io_bus.digit_i_valid;
    // A digit arriving in the expiry cycle still counts as a real answer.
    assign w_timeout       = w_in_wait && !io_bus.digit_i_valid && w_expire;
    assign w_frame_end     = w_digit_acc || w_timeout;
    assign w_frame_idx_inc = r_frame_idx + 16'd1;
    assign w_last_frame    = (r_num_frames != 16'd0) && (w_frame_idx_inc == r_num_frames);

    seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_in_wait),
        .i_en     (w_in_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (io_bus.start) w_next_state = STREAM;
                end
                STREAM: begin
                    if (w_last_pop) w_next_state = WAIT_RESULT;
                end
                WAIT_RESULT: begin
                    if (w_frame_end) w_next_state = w_last_frame ? DONE : STREAM;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            STREAM: begin
                w_busy  = 1'b1;
                w_rd_en = !io_bus.fifo_empty;
            end
            WAIT_RESULT: w_busy = 1'b1;
            DONE:        w_done = 1'b1;
            default: ;
        endcase
    end

    // Abort drops the frame in flight but leaves the sticky error flags for the host to read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pix_cnt      <= '0;
            r_num_frames   <= '0;
            r_frame_idx    <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_spurious_err <= 1'b0;
        end else if (w_abort) begin
            r_pix_cnt      <= '0;
            r_frame_idx    <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_frame_end;
            if (w_start_ok) begin
                r_num_frames   <= io_bus.num_frames;
                r_frame_idx    <= '0;
                r_pix_cnt      <= '0;
                r_timeout_err  <= 1'b0;
                r_spurious_err <= 1'b0;
            end
            if (w_rd_en) begin
                r_pix_cnt <= w_last_pop ? '0 : r_pix_cnt + 1'b1;
            end
            if (w_frame_end) begin
                r_result    <= w_digit_acc ? io_bus.digit_i : BCD_BITS'(RESULT_TIMEOUT);
                r_frame_idx <= w_frame_idx_inc;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (io_bus.digit_i_valid && !w_in_wait) begin
                r_spurious_err <= 1'b1;
            end
        end
    end

    assign w_unused_dout = &{1'b0, io_bus.fifo_dout[D_WIDTH-1:GS_BITS]};

    assign io_bus.fifo_rd_en    = w_rd_en;
    assign io_bus.pixel_o_valid = w_rd_en;
    assign io_bus.pixel_o       = io_bus.fifo_dout[GS_BITS-1:0];
    assign io_bus.result_o      = r_result;
    assign io_bus.result_valid  = r_result_valid;
    assign io_bus.frame_idx_o   = r_frame_idx;
    assign io_bus.busy          = w_busy;
    assign io_bus.done          = w_done;
    assign io_bus.timeout_err   = r_timeout_err;
    assign io_bus.spurious_err  = r_spurious_err;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench: FIFO model + scoreboard queues of expected pixels and results, checked by a monitor.
module tb_cnn_frame_sequencer;

    localparam int GS   = 8;
    localparam int BCD  = 4;
    localparam int DW   = 16;
    localparam int DIM  = 4;
    localparam int TMO  = 20;
    localparam int NPIX = DIM * DIM;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] idx;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_frame_sequencer_if #(.GS_BITS(GS), .BCD_BITS(BCD), .D_WIDTH(DW)) bus ();

    cnn_frame_sequencer #(
        .GS_BITS(GS), .BCD_BITS(BCD), .D_WIDTH(DW), .IMG_DIM(DIM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] fifo_q[$];
    logic [7:0]  exp_pix[$];
    res_t        exp_res[$];
    int  cyc = 0, frame_pops = 0, last_pop_cyc = 0, res_cyc = 0, res_seen = 0, pix_seen = 0;
    bit  stall = 0, done_seen = 0;
    logic [7:0] mon_pix;
    res_t       mon_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event not seen within cycle budget", name);
    endtask

    always @(negedge clk) begin
        if (bus.pixel_o_valid === 1'b1) begin
            pix_seen++;
            if (exp_pix.size() == 0) begin
                bound_fail("unexpected_pixel");
            end else begin
                mon_pix = exp_pix.pop_front();
                chk("pixel_o", 32'(bus.pixel_o), 32'(mon_pix));
            end
        end
        if (bus.result_valid === 1'b1) begin
            res_seen++;
            res_cyc = cyc;
            if (exp_res.size() == 0) begin
                bound_fail("unexpected_result_valid");
            end else begin
                mon_res = exp_res.pop_front();
                chk("result_o", 32'(bus.result_o), 32'(mon_res.d));
                chk("frame_idx_o_at_result", 32'(bus.frame_idx_o), 32'(mon_res.idx));
            end
        end
        if (bus.done === 1'b1) done_seen = 1'b1;
    end

    task automatic refresh();
        bus.fifo_empty = stall || (fifo_q.size() == 0);
        bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic tick();
        bit pop;
        @(negedge clk);
        pop = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(fifo_q.pop_front());
            frame_pops++;
            last_pop_cyc = cyc;
        end
        cyc++;
        refresh();
    endtask

    task automatic load_n(input logic [7:0] seed, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = seed + 8'(i);
            fifo_q.push_back({8'h5A ^ p, p});
            exp_pix.push_back(p);
        end
        refresh();
    endtask

    task automatic pulse_start(input logic [15:0] nf);
        bus.num_frames = nf;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        frame_pops = 0;
    endtask

    task automatic stream_until(input int n);
        int guard;
        guard = 0;
        while (frame_pops < n && guard < 200) begin
            tick();
            guard++;
        end
        if (frame_pops < n) bound_fail("stream_until");
    endtask

    task automatic stream_frame(input int stall_at, input int stall_len, input int spur_a, input int spur_b);
        int guard;
        bit stalled, sa, sb;
        guard = 0; stalled = 0; sa = 0; sb = 0;
        while (frame_pops < NPIX && guard < 200) begin
            if (!stalled && frame_pops == stall_at) begin
                stalled = 1;
                stall = 1;
                refresh();
                repeat (stall_len) tick();
                chk("stall_holds_pops", 32'(frame_pops), 32'(stall_at));
                stall = 0;
                refresh();
            end
            bus.digit_i_valid = 1'b0;
            if (!sa && frame_pops == spur_a) begin
                sa = 1;
                bus.digit_i = 4'hE;
                bus.digit_i_valid = 1'b1;
            end else if (!sb && frame_pops == spur_b) begin
                sb = 1;
                bus.digit_i = 4'hD;
                bus.digit_i_valid = 1'b1;
            end
            tick();
            guard++;
        end
        bus.digit_i_valid = 1'b0;
        if (frame_pops < NPIX) bound_fail("stream_frame");
        frame_pops = 0;
    endtask

    task automatic give_digit(input logic [3:0] d, input int delay, input logic [15:0] idx);
        res_t r;
        repeat (delay) tick();
        r.d = d;
        r.idx = idx;
        exp_res.push_back(r);
        bus.digit_i = d;
        bus.digit_i_valid = 1'b1;
        tick();
        bus.digit_i_valid = 1'b0;
    endtask

    task automatic wait_result(input int n);
        int guard;
        guard = 0;
        while (res_seen < n && guard < 100) begin
            tick();
            guard++;
        end
        if (res_seen < n) bound_fail("wait_result");
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifo_rd_en"}, 32'(bus.fifo_rd_en), 0);
        chk({tag, "_pixel_o_valid"}, 32'(bus.pixel_o_valid), 0);
        chk({tag, "_result_o"}, 32'(bus.result_o), 0);
        chk({tag, "_result_valid"}, 32'(bus.result_valid), 0);
        chk({tag, "_frame_idx_o"}, 32'(bus.frame_idx_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
        chk({tag, "_spurious_err"}, 32'(bus.spurious_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0, entry;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_frames = 16'd0;
        bus.digit_i = 4'd0;
        bus.digit_i_valid = 1'b0;
        refresh();
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // 1: single frame, digit 7 five cycles after the last pop
        pix_seen = 0;
        load_n(8'h10, NPIX);
        pulse_start(16'd1);
        chk("t1_busy", 32'(bus.busy), 1);
        stream_frame(-1, 0, -1, -1);
        chk("t1_pixel_count", 32'(pix_seen), 16);
        chk("t1_no_pop_in_wait", 32'(bus.fifo_rd_en), 0);
        give_digit(4'd7, 4, 16'd1);
        chk("t1_done", 32'(bus.done), 1);
        wait_result(1);
        repeat (3) tick();
        chk("t1_single_pulse", 32'(res_seen), 1);
        chk("t1_frame_idx", 32'(bus.frame_idx_o), 1);
        chk("t1_busy_clear", 32'(bus.busy), 0);

        // 2: three frames, FIFO stalls 5 cycles mid frame 2, spare words must stay put
        pix_seen = 0;
        load_n(8'h20, NPIX);
        load_n(8'h40, NPIX);
        load_n(8'h60, NPIX);
        load_n(8'hF0, 4);
        pulse_start(16'd3);
        bus.num_frames = 16'd1;
        stream_frame(-1, 0, -1, -1);
        give_digit(4'd1, 2, 16'd1);
        chk("t2_not_done_f1", 32'(bus.done), 0);
        stream_frame(5, 5, -1, -1);
        give_digit(4'd2, 0, 16'd2);
        chk("t2_not_done_f2", 32'(bus.done), 0);
        stream_frame(-1, 0, -1, -1);
        give_digit(4'd3, 1, 16'd3);
        chk("t2_done", 32'(bus.done), 1);
        wait_result(4);
        repeat (5) tick();
        chk("t2_pixel_count", 32'(pix_seen), 48);
        chk("t2_spare_words", 32'(fifo_q.size()), 4);
        fifo_q.delete();
        exp_pix.delete();
        refresh();

        // 3: first frame times out, second is answered
        load_n(8'h80, NPIX);
        load_n(8'h90, NPIX);
        pulse_start(16'd2);
        stream_frame(-1, 0, -1, -1);
        entry = last_pop_cyc;
        chk("t3_timeout_err_pre", 32'(bus.timeout_err), 0);
        begin
            res_t r;
            r.d = 4'hF;
            r.idx = 16'd1;
            exp_res.push_back(r);
        end
        wait_result(5);
        chk("t3_timeout_latency", 32'(res_cyc - entry), 21);
        chk("t3_timeout_err", 32'(bus.timeout_err), 1);
        stream_frame(-1, 0, -1, -1);
        give_digit(4'd5, 0, 16'd2);
        chk("t3_done", 32'(bus.done), 1);
        wait_result(6);
        chk("t3_timeout_err_sticky", 32'(bus.timeout_err), 1);

        // 4: spurious digits during STREAM and on the last pop
        load_n(8'hA0, NPIX);
        pulse_start(16'd1);
        chk("t4_timeout_err_cleared", 32'(bus.timeout_err), 0);
        chk("t4_spurious_pre", 32'(bus.spurious_err), 0);
        stream_frame(-1, 0, 3, 15);
        chk("t4_spurious_err", 32'(bus.spurious_err), 1);
        r0 = res_seen;
        repeat (3) tick();
        chk("t4_no_result", 32'(res_seen), 32'(r0));
        give_digit(4'd4, 0, 16'd1);
        wait_result(r0 + 1);
        chk("t4_done", 32'(bus.done), 1);

        // 5a: abort at pixel 9, then a fresh frame counts from 0
        load_n(8'hB0, NPIX);
        pulse_start(16'd1);
        stream_until(9);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t5_abort_busy", 32'(bus.busy), 0);
        chk("t5_abort_done", 32'(bus.done), 0);
        chk("t5_abort_frame_idx", 32'(bus.frame_idx_o), 0);
        chk("t5_abort_rd_en", 32'(bus.fifo_rd_en), 0);
        r0 = res_seen;
        repeat (3) tick();
        chk("t5_abort_no_pulse", 32'(res_seen), 32'(r0));
        load_n(8'hC0, NPIX - fifo_q.size());
        pulse_start(16'd1);
        stream_frame(-1, 0, -1, -1);
        give_digit(4'd9, 0, 16'd1);
        chk("t5_restart_done", 32'(bus.done), 1);
        wait_result(r0 + 1);

        // 5b: reset mid-frame clears everything
        load_n(8'hD0, NPIX);
        pulse_start(16'd1);
        stream_until(9);
        bus.digit_i_valid = 1'b1;
        tick();
        bus.digit_i_valid = 1'b0;
        chk("t5_spurious_set", 32'(bus.spurious_err), 1);
        rst = 1'b0;
        tick();
        chk_all_zero("t5_midrst");
        rst = 1'b1;
        fifo_q.delete();
        exp_pix.delete();
        refresh();
        tick();

        // 6: num_frames=0 runs continuously
        load_n(8'h01, NPIX * 5);
        r0 = res_seen;
        pulse_start(16'd0);
        done_seen = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            stream_frame(-1, 0, -1, -1);
            give_digit(4'(f), 1, 16'(f));
        end
        wait_result(r0 + 5);
        tick();
        chk("t6_frame_idx", 32'(bus.frame_idx_o), 5);
        chk("t6_busy", 32'(bus.busy), 1);
        chk("t6_done_never", 32'(done_seen), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t6_abort_idle", 32'(bus.busy), 0);
        chk("results_drained", 32'(exp_res.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
